mem_accum_engine: RTL and testbench

- Parametrised successor to the multi-cycle memory accumulator controller. Controller and datapath are merged into one block.
- On go, reads LEN words from a synchronous-read memory, starting at START_ADDR. Issues one read per cycle (pipelined, not 4 cycles per word).
- Combines the words under a selectable mode, latches the result and pulses done.
- Sits between the test/control logic and a single-port block RAM; owns that RAM's read port.

---
 rtl/mem_accum_pkg.sv | 31 +++
 rtl/accum_alu.sv | 61 ++++++
 rtl/mem_accum_engine.sv | 190 +++++++++++++++++++
 tb/tb_mem_accum_engine.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_accum_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_accum_pkg
//  Description : Shared definitions for the memory accumulation engine:
//                FSM state encoding, combine-mode codes and the helper that
//                gives the accumulator's starting value for each mode.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_accum_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic [1:0] MODE_SUM = 2'b00;  // wrapping sum
   localparam logic [1:0] MODE_SAT = 2'b01;  // saturating sum
   localparam logic [1:0] MODE_MAX = 2'b10;  // unsigned maximum
   localparam logic [1:0] MODE_MIN = 2'b11;  // unsigned minimum

   // The identity is either all zeros (sum, max) or all ones (min). The
   // accumulator width is a module parameter, so this returns the fill bit
   // and the caller replicates it to the accumulator width.
   function automatic logic identity_fill(input logic [1:0] mode);
      return (mode == MODE_MIN);
   endfunction

endpackage
`default_nettype wire

// File: rtl/accum_alu.sv
`default_nettype none
// ============================================================================
//  Module      : accum_alu
//  Description : Combinational combine step. Folds one zero-extended memory
//                word into the accumulator according to the selected mode.
//  Ports       : acc_i      current accumulator value
//                data_i     memory word
//                mode_i     combine mode (sum / sat / max / min)
//                next_acc_o updated accumulator value
//                ovf_hit_o  carry out (sum) or clamp (sat) on this step
//  Revision    : 1.0 - initial release
// ============================================================================
module accum_alu
   import mem_accum_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 12
)
(
   input  logic [ACC_W-1:0]  acc_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [1:0]        mode_i,
   output logic [ACC_W-1:0]  next_acc_o,
   output logic              ovf_hit_o
);

   localparam int SUM_W = ACC_W + 1;

   logic [ACC_W-1:0] data_ext;
   logic [SUM_W-1:0] sum;

   assign data_ext = ACC_W'(data_i);
   // One extra bit keeps the carry out of the accumulator width.
   assign sum      = SUM_W'(acc_i) + SUM_W'(data_i);

   always_comb begin
      next_acc_o = acc_i;
      ovf_hit_o  = 1'b0;
      case (mode_i)
         MODE_SUM: begin
            next_acc_o = sum[ACC_W-1:0];
            ovf_hit_o  = sum[ACC_W];
         end
         MODE_SAT: begin
            next_acc_o = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
            ovf_hit_o  = sum[ACC_W];
         end
         MODE_MAX: begin
            if (data_ext > acc_i) next_acc_o = data_ext;
         end
         MODE_MIN: begin
            if (data_ext < acc_i) next_acc_o = data_ext;
         end
         default: begin
            next_acc_o = acc_i;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_accum_engine.sv
`default_nettype none
// ============================================================================
//  Module      : mem_accum_engine
//  Description : Streams LEN words out of a synchronous-read RAM starting at
//                START_ADDR (one read per clock, address wraps), folds them
//                into an accumulator and publishes the result with a
//                one-cycle done pulse.
//  Ports       : clk, rst          clock, synchronous active-high reset
//                go_i              start request (IDLE only)
//                start_addr_i      first read address   (captured on go)
//                len_i             word count 0..DEPTH  (captured on go)
//                mode_i            combine mode         (captured on go)
//                abort_i           cancel a run in progress
//                mem_rd_o          RAM read strobe
//                mem_addr_o        RAM read address
//                mem_rdata_i       RAM data, valid one cycle after mem_rd_o
//                busy_o            high outside IDLE
//                done_o            one-cycle pulse when result_o updates
//                result_o, ovf_o   last published result and overflow flag
//                ps_o              current state, for debug
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_accum_engine
   import mem_accum_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int ACC_W  = 12
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              go_i,
   input  logic [ADDR_W-1:0] start_addr_i,
   input  logic [ADDR_W:0]   len_i,
   input  logic [1:0]        mode_i,
   input  logic              abort_i,
   output logic              mem_rd_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [ACC_W-1:0]  result_o,
   output logic              ovf_o,
   output logic [1:0]        ps_o
);

   localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   remain_q, remain_d;
   logic [1:0]        mode_q, mode_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic              ovf_int_q, ovf_int_d;
   logic [ACC_W-1:0]  result_q, result_d;
   logic              ovf_q, ovf_d;
   logic              rd_q;       // a read was issued last cycle -> data valid now

   logic [ACC_W-1:0]  alu_next;
   logic              alu_ovf;
   logic              start_ok;

   assign start_ok = go_i && !abort_i;

   accum_alu #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_alu (
      .acc_i      (acc_q),
      .data_i     (mem_rdata_i),
      .mode_i     (mode_q),
      .next_acc_o (alu_next),
      .ovf_hit_o  (alu_ovf)
   );

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         remain_q  <= '0;
         mode_q    <= '0;
         acc_q     <= '0;
         ovf_int_q <= 1'b0;
         result_q  <= '0;
         ovf_q     <= 1'b0;
         rd_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         remain_q  <= remain_d;
         mode_q    <= mode_d;
         acc_q     <= acc_d;
         ovf_int_q <= ovf_int_d;
         result_q  <= result_d;
         ovf_q     <= ovf_d;
         rd_q      <= (state_q == ST_READ) && !abort_i;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start_ok) state_d = (len_i == '0) ? ST_DONE : ST_READ;
         end
         ST_READ: begin
            if (abort_i)                state_d = ST_IDLE;
            else if (remain_q == CNT_ONE) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            state_d = abort_i ? ST_IDLE : ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath next-state: counters, accumulator, published result
   // ------------------------------------------------------------------
   always_comb begin
      addr_d    = addr_q;
      remain_d  = remain_q;
      mode_d    = mode_q;
      acc_d     = acc_q;
      ovf_int_d = ovf_int_q;
      result_d  = result_q;
      ovf_d     = ovf_q;

      if (rd_q) begin
         acc_d     = alu_next;
         ovf_int_d = ovf_int_q | alu_ovf;
      end

      case (state_q)
         ST_IDLE: begin
            if (start_ok) begin
               mode_d    = mode_i;
               remain_d  = len_i;
               ovf_int_d = 1'b0;
               // An empty run publishes zero regardless of mode.
               acc_d     = (len_i == '0) ? '0 : {ACC_W{identity_fill(mode_i)}};
               // Leave the address alone on an empty run so it keeps
               // showing the last address actually read.
               if (len_i != '0) addr_d = start_addr_i;
            end
         end
         ST_READ: begin
            remain_d = remain_q - CNT_ONE;
            // Stop on the last address so it is held once reads end;
            // natural overflow gives the modulo-depth wrap.
            if (remain_q != CNT_ONE) addr_d = addr_q + 1'b1;
         end
         default: begin
         end
      endcase

      // Publish on entry to DONE; the final word is already folded into acc_d.
      if (state_d == ST_DONE && state_q != ST_DONE) begin
         result_d = acc_d;
         ovf_d    = ovf_int_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   always_comb begin
      mem_rd_o   = (state_q == ST_READ);
      mem_addr_o = addr_q;
      busy_o     = (state_q != ST_IDLE);
      done_o     = (state_q == ST_DONE);
      result_o   = result_q;
      ovf_o      = ovf_q;
      ps_o       = state_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_accum_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_accum_engine
//  Description : Self-checking bench. Two engines (ACC_W 12 and 10) share the
//                same stimulus and RAM image; a list-level reference model
//                gives the expected result and overflow for each run.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_accum_engine;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       go;
   logic       abort;
   logic [3:0] start_addr;
   logic [4:0] len;
   logic [1:0] mode;

   logic       mem_rd_a, mem_rd_b;
   logic [3:0] mem_addr_a, mem_addr_b;
   logic [7:0] rdata_a, rdata_b;
   logic       busy_a, busy_b, done_a, done_b, ovf_a, ovf_b;
   logic [11:0] result_a;
   logic [9:0]  result_b;
   logic [1:0]  ps_a, ps_b;

   logic [7:0] ram [DEPTH];

   int n_checks = 0;
   int n_pass   = 0;
   int prev_a   = 0;
   int prev_b   = 0;
   int prev_oa  = 0;
   int prev_ob  = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_rd_a) rdata_a <= ram[mem_addr_a];
      if (mem_rd_b) rdata_b <= ram[mem_addr_b];
   end

   mem_accum_engine #(.DATA_W(8), .ADDR_W(4), .ACC_W(12)) u_dut (
      .clk(clk), .rst(rst), .go_i(go), .start_addr_i(start_addr), .len_i(len),
      .mode_i(mode), .abort_i(abort), .mem_rd_o(mem_rd_a), .mem_addr_o(mem_addr_a),
      .mem_rdata_i(rdata_a), .busy_o(busy_a), .done_o(done_a), .result_o(result_a),
      .ovf_o(ovf_a), .ps_o(ps_a)
   );

   mem_accum_engine #(.DATA_W(8), .ADDR_W(4), .ACC_W(10)) u_dut10 (
      .clk(clk), .rst(rst), .go_i(go), .start_addr_i(start_addr), .len_i(len),
      .mode_i(mode), .abort_i(abort), .mem_rd_o(mem_rd_b), .mem_addr_o(mem_addr_b),
      .mem_rdata_i(rdata_b), .busy_o(busy_b), .done_o(done_b), .result_o(result_b),
      .ovf_o(ovf_b), .ps_o(ps_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Reference: fold the list of words read, using plain integer arithmetic.
   function automatic void model(input int st, input int ln, input int md, input int w,
                                 output int res, output int ovf);
      int total;
      int mx;
      int mn;
      int d;
      int lim;
      total = 0;
      mx    = 0;
      mn    = 1 << 30;
      lim   = 1 << w;
      res   = 0;
      ovf   = 0;
      if (ln == 0) return;
      for (int k = 0; k < ln; k++) begin
         d = int'(ram[(st + k) % DEPTH]);
         total += d;
         if (d > mx) mx = d;
         if (d < mn) mn = d;
      end
      case (md)
         0: begin res = total % lim;                   ovf = (total >= lim) ? 1 : 0; end
         1: begin res = (total >= lim) ? lim - 1 : total; ovf = (total >= lim) ? 1 : 0; end
         2: res = mx;
         default: res = mn;
      endcase
   endfunction

   // One complete run; every cycle's handshake is checked against the
   // expected schedule, and optionally the inputs are scrambled mid-run.
   task automatic run_op(input int st, input int ln, input int md, input bit scramble);
      int ea, eoa, eb, eob, last;
      model(st, ln, md, 12, ea, eoa);
      model(st, ln, md, 10, eb, eob);
      last = (ln == 0) ? 1 : ln + 2;
      @(negedge clk);
      go = 1'b1; start_addr = st[3:0]; len = ln[4:0]; mode = md[1:0];
      for (int c = 1; c <= last; c++) begin
         @(negedge clk);
         check("busy", 32'(busy_a), 1);
         if (c <= ln) begin
            check("mem_rd", 32'(mem_rd_a), 1);
            check("mem_addr", 32'(mem_addr_a), (st + c - 1) % DEPTH);
            check("done_early", 32'(done_a), 0);
         end else if (c < last) begin
            check("drain_rd", 32'(mem_rd_a), 0);
            check("drain_ps", 32'(ps_a), 2);
         end else begin
            check("done", 32'(done_a), 1);
            check("done_ps", 32'(ps_a), 3);
            check("done_rd", 32'(mem_rd_a), 0);
            check("result12", 32'(result_a), ea);
            check("ovf12", 32'(ovf_a), eoa);
            check("result10", 32'(result_b), eb);
            check("ovf10", 32'(ovf_b), eob);
         end
         go = (scramble && c < ln) ? 1'($urandom % 2) : 1'b0;
         if (scramble) begin
            start_addr = 4'($urandom);
            len        = 5'($urandom_range(0, 16));
            mode       = 2'($urandom);
         end
      end
      go = 1'b0;
      @(negedge clk);
      check("idle_busy", 32'(busy_a), 0);
      check("idle_done", 32'(done_a), 0);
      check("hold12", 32'(result_a), ea);
      check("hold10", 32'(result_b), eb);
      prev_a = ea; prev_b = eb; prev_oa = eoa; prev_ob = eob;
   endtask

   initial begin
      rst = 1'b1; go = 1'b0; abort = 1'b0;
      start_addr = '0; len = '0; mode = '0;
      for (int i = 0; i < DEPTH; i++) ram[i] = 8'd0;
      repeat (3) @(negedge clk);
      check("rst_rd", 32'(mem_rd_a), 0);
      check("rst_addr", 32'(mem_addr_a), 0);
      check("rst_busy", 32'(busy_a), 0);
      check("rst_done", 32'(done_a), 0);
      check("rst_result", 32'(result_a), 0);
      check("rst_ovf", 32'(ovf_a), 0);
      check("rst_ps", 32'(ps_a), 0);
      rst = 1'b0;

      // Basic wrapping sum of four words.
      ram[0] = 8'd10; ram[1] = 8'd20; ram[2] = 8'd30; ram[3] = 8'd40;
      run_op(0, 4, 0, 1'b0);

      // All-255 image, full depth: saturating then wrapping sum.
      for (int i = 0; i < DEPTH; i++) ram[i] = 8'd255;
      run_op(0, 16, 1, 1'b0);
      run_op(0, 16, 0, 1'b0);

      // Wrapping address window with max and min.
      for (int i = 0; i < DEPTH; i++) ram[i] = 8'd100;
      ram[14] = 8'd3; ram[15] = 8'd9; ram[0] = 8'd1; ram[1] = 8'd7;
      run_op(14, 4, 2, 1'b0);
      run_op(14, 4, 3, 1'b1);

      // Empty run.
      run_op(5, 0, 3, 1'b0);
      run_op(14, 4, 3, 1'b0);

      // Abort on the second READ cycle: result keeps the previous value.
      @(negedge clk);
      go = 1'b1; start_addr = 4'd2; len = 5'd6; mode = 2'd0;
      @(negedge clk);
      go = 1'b0;
      check("ab_rd1", 32'(mem_rd_a), 1);
      @(negedge clk);
      check("ab_rd2", 32'(mem_addr_a), 3);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("ab_busy", 32'(busy_a), 0);
      check("ab_rd", 32'(mem_rd_a), 0);
      check("ab_ps", 32'(ps_a), 0);
      check("ab_result12", 32'(result_a), prev_a);
      check("ab_result10", 32'(result_b), prev_b);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("ab_nodone", 32'(done_a), 0);
      end

      // abort together with go in IDLE: no start.
      go = 1'b1; abort = 1'b1;
      @(negedge clk);
      go = 1'b0; abort = 1'b0;
      check("abgo_busy", 32'(busy_a), 0);

      // go held high: back-to-back runs separated by one IDLE cycle.
      for (int i = 0; i < DEPTH; i++) ram[i] = 8'(i * 3 + 1);
      begin
         int ea, eoa, eb, eob;
         model(4, 3, 0, 12, ea, eoa);
         model(4, 3, 0, 10, eb, eob);
         go = 1'b1; start_addr = 4'd4; len = 5'd3; mode = 2'd0;
         for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c == 5 || c == 11) begin
               check("b2b_done", 32'(done_a), 1);
               check("b2b_result", 32'(result_a), ea);
               check("b2b_result10", 32'(result_b), eb);
            end else begin
               check("b2b_nodone", 32'(done_a), 0);
            end
            if (c == 6) check("b2b_idle", 32'(busy_a), 0);
            if (c == 7) begin
               check("b2b_rd", 32'(mem_rd_a), 1);
               check("b2b_addr", 32'(mem_addr_a), 4);
               go = 1'b0;
            end
         end
         @(negedge clk);
         check("b2b_stop", 32'(busy_a), 0);
      end

      // Randomized runs against the model.
      for (int t = 0; t < 24; t++) begin
         for (int i = 0; i < DEPTH; i++) ram[i] = 8'($urandom);
         run_op(int'($urandom % DEPTH), int'($urandom_range(0, 16)),
                int'($urandom % 4), 1'($urandom % 2));
      end

      // Reset pulse in the middle of READ.
      @(negedge clk);
      go = 1'b1; start_addr = 4'd7; len = 5'd8; mode = 2'd1;
      @(negedge clk);
      go = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mrst_rd", 32'(mem_rd_a), 0);
      check("mrst_addr", 32'(mem_addr_a), 0);
      check("mrst_busy", 32'(busy_a), 0);
      check("mrst_result", 32'(result_a), 0);
      check("mrst_result10", 32'(result_b), 0);
      check("mrst_ovf", 32'(ovf_a), 0);
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         check("mrst_nodone", 32'(done_a), 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
